// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the BEQZ/BNEZ branch resolution controller.
//   - br_state_e   : controller state encoding
//   - OP_BEQZ/BNEZ : br_op encodings
//   - OPND_W       : width of the A operand (fixed 32-bit DLX register)
//   - branch_taken : taken decision from the op and the zero flag
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int unsigned OPND_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        RESOLVE   = 2'd2,
        REDIRECT  = 2'd3
    } br_state_e;

    localparam logic OP_BEQZ = 1'b0;
    localparam logic OP_BNEZ = 1'b1;

    // BEQZ is taken when A is zero, BNEZ when it is not.
    function automatic logic branch_taken(input logic op, input logic zero);
        return (op == OP_BNEZ) ? !zero : zero;
    endfunction

endpackage : branch_pkg

// File: rtl/branch_eqz_ctrl_zdet.sv
// -----------------------------------------------------------------------------
// branch_eqz_ctrl_zdet
// 32-bit zero-detect unit. Purely combinational: zero is high when every bit
// of the operand is clear. Built as a nibble-level OR stage followed by a
// final reduction so the two levels map onto a shallow gate tree.
// Ports:
//   opnd  input  [OPND_W-1:0]  operand to test
//   zero  output               1 when opnd == 0
// -----------------------------------------------------------------------------
module branch_eqz_ctrl_zdet
    import branch_pkg::*;
(
    input  logic [OPND_W-1:0] opnd,
    output logic              zero
);

    localparam int unsigned NIB = OPND_W / 4;

    logic [NIB-1:0] nib_any;

    always_comb begin
        nib_any = '0;
        for (int i = 0; i < NIB; i++) begin
            nib_any[i] = |opnd[4*i +: 4];
        end
    end

    assign zero = ~|nib_any;

endmodule : branch_eqz_ctrl_zdet

// File: rtl/branch_eqz_ctrl.sv
// -----------------------------------------------------------------------------
// branch_eqz_ctrl
// Sequences BEQZ/BNEZ resolution: accepts a branch from decode, waits for the
// A operand, evaluates A==0 and hands a registered redirect decision to the
// fetch/PC logic over a valid/ready handshake. Keeps a saturating count of
// consumed taken branches. Flush discards any in-flight branch.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   br_valid/br_ready   branch request handshake from decode
//   br_op, br_target    0=BEQZ 1=BNEZ, branch target (latched on accept)
//   a_valid, a_data     A operand (forwarded or register file)
//   flush               drop in-flight branch, return to IDLE
//   redirect_valid/ready, redirect_taken, redirect_target  decision to PC logic
//   busy                controller not idle (decode stall)
//   taken_cnt           saturating count of consumed taken redirects
// -----------------------------------------------------------------------------
module branch_eqz_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic              br_op,
    input  logic [AW-1:0]     br_target,
    input  logic              a_valid,
    input  logic [OPND_W-1:0] a_data,
    input  logic              flush,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic              redirect_taken,
    output logic [AW-1:0]     redirect_target,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt
);

    // Counter increments but sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    br_state_e          state_q,      state_d;
    logic               op_q,         op_d;
    logic [AW-1:0]      tgt_q,        tgt_d;
    logic [OPND_W-1:0]  a_q,          a_d;
    logic               rvalid_q,     rvalid_d;
    logic               rtaken_q,     rtaken_d;
    logic [AW-1:0]      rtarget_q,    rtarget_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;

    logic               a_zero;

    // Zero detect always looks at the latched operand, never at a_data, so the
    // decision in RESOLVE is independent of what the bus does afterwards.
    branch_eqz_ctrl_zdet u_zdet (
        .opnd (a_q),
        .zero (a_zero)
    );

    assign br_ready = (state_q == IDLE) && !flush;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tgt_d     = tgt_q;
        a_d       = a_q;
        rvalid_d  = rvalid_q;
        rtaken_d  = rtaken_q;
        rtarget_d = rtarget_q;
        cnt_d     = cnt_q;

        if (flush) begin
            // Flush beats both a pending handshake and a new request.
            state_d  = IDLE;
            rvalid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (br_valid) begin
                        op_d  = br_op;
                        tgt_d = br_target;
                        if (a_valid) begin
                            a_d     = a_data;
                            state_d = RESOLVE;
                        end else begin
                            state_d = WAIT_OPND;
                        end
                    end
                end
                WAIT_OPND: begin
                    if (a_valid) begin
                        a_d     = a_data;
                        state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    rtaken_d  = branch_taken(op_q, a_zero);
                    rtarget_d = tgt_q;
                    rvalid_d  = 1'b1;
                    state_d   = REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        rvalid_d = 1'b0;
                        state_d  = IDLE;
                        if (rtaken_q) begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_BEQZ;
            tgt_q     <= '0;
            a_q       <= '0;
            rvalid_q  <= 1'b0;
            rtaken_q  <= 1'b0;
            rtarget_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tgt_q     <= tgt_d;
            a_q       <= a_d;
            rvalid_q  <= rvalid_d;
            rtaken_q  <= rtaken_d;
            rtarget_q <= rtarget_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign redirect_valid  = rvalid_q;
    assign redirect_taken  = rtaken_q;
    assign redirect_target = rtarget_q;
    assign taken_cnt       = cnt_q;

endmodule : branch_eqz_ctrl

// File: tb/tb_branch_eqz_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_eqz_ctrl
// Directed bench for branch_eqz_ctrl (CNT_W=4 so saturation is reachable).
// Stimulus pushes the expected redirect into a queue; a monitor pops and
// compares on every redirect handshake.
// -----------------------------------------------------------------------------
module tb_branch_eqz_ctrl;

    localparam int AW    = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             br_valid;
    logic             br_ready;
    logic             br_op;
    logic [AW-1:0]    br_target;
    logic             a_valid;
    logic [31:0]      a_data;
    logic             flush;
    logic             redirect_valid;
    logic             redirect_ready;
    logic             redirect_taken;
    logic [AW-1:0]    redirect_target;
    logic             busy;
    logic [CNT_W-1:0] taken_cnt;

    branch_eqz_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .br_valid        (br_valid),
        .br_ready        (br_ready),
        .br_op           (br_op),
        .br_target       (br_target),
        .a_valid         (a_valid),
        .a_data          (a_data),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_ready  (redirect_ready),
        .redirect_taken  (redirect_taken),
        .redirect_target (redirect_target),
        .busy            (busy),
        .taken_cnt       (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          taken;
        logic [AW-1:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic taken, input logic [AW-1:0] tgt);
        exp_t e;
        e.taken = taken;
        e.tgt   = tgt;
        sb_q.push_back(e);
    endtask

    // Inputs change 2 time units after the rising edge; checks run there too.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every accepted redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && !flush && redirect_valid && redirect_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got redirect taken=%0d target=0x%0h, required none",
                         redirect_taken, redirect_target);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_taken", 64'(redirect_taken), 64'(e.taken));
                chk("sb_target", 64'(redirect_target), 64'(e.tgt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        br_valid       = 1'b0;
        br_op          = 1'b0;
        br_target      = '0;
        a_valid        = 1'b0;
        a_data         = '0;
        flush          = 1'b0;
        redirect_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_rvalid", 64'(redirect_valid), 64'd0);
        chk("rst_rtaken", 64'(redirect_taken), 64'd0);
        chk("rst_rtarget", 64'(redirect_target), 64'd0);
        chk("rst_cnt", 64'(taken_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1 chk("rst_br_ready", 64'(br_ready), 64'd1);
        step();

        // BEQZ, operand valid at accept: redirect in cycle 2
        br_valid = 1'b1; br_op = 1'b0; br_target = 32'h100;
        a_valid = 1'b1; a_data = 32'h0; redirect_ready = 1'b1;
        push_exp(1'b1, 32'h100);
        #1 chk("t1_br_ready_c0", 64'(br_ready), 64'd1);
        step();
        br_valid = 1'b0; a_valid = 1'b0; a_data = 32'h1234;
        chk("t1_rvalid_c1", 64'(redirect_valid), 64'd0);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        step();
        chk("t1_rvalid_c2", 64'(redirect_valid), 64'd1);
        chk("t1_rtaken_c2", 64'(redirect_taken), 64'd1);
        chk("t1_rtarget_c2", 64'(redirect_target), 64'h100);
        step();
        chk("t1_br_ready_c3", 64'(br_ready), 64'd1);
        chk("t1_rvalid_c3", 64'(redirect_valid), 64'd0);
        chk("t1_cnt", 64'(taken_cnt), 64'd1);

        // BNEZ, operand arrives three cycles after accept
        br_valid = 1'b1; br_op = 1'b1; br_target = 32'h200; a_valid = 1'b0;
        push_exp(1'b1, 32'h200);
        step();
        br_valid = 1'b0; br_op = 1'b0; br_target = 32'hDEAD;
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) begin
                a_valid = 1'b1; a_data = 32'h5;
            end else begin
                a_valid = 1'b0; a_data = 32'h0;
            end
            chk($sformatf("t2_busy_c%0d", c), 64'(busy), 64'd1);
            chk($sformatf("t2_rvalid_c%0d", c), 64'(redirect_valid), 64'd0);
            step();
        end
        chk("t2_rvalid_c5", 64'(redirect_valid), 64'd1);
        chk("t2_rtaken_c5", 64'(redirect_taken), 64'd1);
        chk("t2_rtarget_c5", 64'(redirect_target), 64'h200);
        step();
        chk("t2_busy_c6", 64'(busy), 64'd0);
        chk("t2_cnt", 64'(taken_cnt), 64'd2);

        // Not taken with four cycles of backpressure
        br_valid = 1'b1; br_op = 1'b0; br_target = 32'h300;
        a_valid = 1'b1; a_data = 32'hFFFF_FFFF; redirect_ready = 1'b0;
        push_exp(1'b0, 32'h300);
        step();
        br_valid = 1'b0; a_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_rvalid_hold%0d", k), 64'(redirect_valid), 64'd1);
            chk($sformatf("t3_rtaken_hold%0d", k), 64'(redirect_taken), 64'd0);
            chk($sformatf("t3_rtarget_hold%0d", k), 64'(redirect_target), 64'h300);
            step();
        end
        redirect_ready = 1'b1;
        chk("t3_rvalid_last", 64'(redirect_valid), 64'd1);
        step();
        chk("t3_busy_after", 64'(busy), 64'd0);
        chk("t3_rvalid_after", 64'(redirect_valid), 64'd0);
        chk("t3_cnt", 64'(taken_cnt), 64'd2);

        // Flush while waiting for the operand
        br_valid = 1'b1; br_op = 1'b0; br_target = 32'h400; a_valid = 1'b0;
        step();
        chk("t4_busy_wait", 64'(busy), 64'd1);
        flush = 1'b1;
        #1 chk("t4_br_ready_flush", 64'(br_ready), 64'd0);
        step();
        flush = 1'b0; br_valid = 1'b0;
        chk("t4_busy_after", 64'(busy), 64'd0);
        a_valid = 1'b1; a_data = 32'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_rvalid_never%0d", k), 64'(redirect_valid), 64'd0);
            chk($sformatf("t4_busy_idle%0d", k), 64'(busy), 64'd0);
        end
        a_valid = 1'b0;

        // Flush beats a request in IDLE
        br_valid = 1'b1; flush = 1'b1; br_target = 32'h480;
        #1 chk("t4b_br_ready", 64'(br_ready), 64'd0);
        step();
        br_valid = 1'b0; flush = 1'b0;
        chk("t4b_busy", 64'(busy), 64'd0);

        // Flush together with redirect_ready in REDIRECT
        br_valid = 1'b1; br_op = 1'b0; br_target = 32'h500;
        a_valid = 1'b1; a_data = 32'h0; redirect_ready = 1'b0;
        step();
        br_valid = 1'b0; a_valid = 1'b0;
        step();
        chk("t5_rvalid_redirect", 64'(redirect_valid), 64'd1);
        flush = 1'b1; redirect_ready = 1'b1;
        #1 chk("t5_br_ready_flush", 64'(br_ready), 64'd0);
        step();
        flush = 1'b0; redirect_ready = 1'b0;
        chk("t5_rvalid_after", 64'(redirect_valid), 64'd0);
        chk("t5_busy_after", 64'(busy), 64'd0);
        chk("t5_cnt", 64'(taken_cnt), 64'd2);

        // Reset while presenting a redirect
        br_valid = 1'b1; br_op = 1'b0; br_target = 32'h600;
        a_valid = 1'b1; a_data = 32'h0;
        step();
        br_valid = 1'b0; a_valid = 1'b0;
        step();
        chk("t6_rvalid_before", 64'(redirect_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rvalid", 64'(redirect_valid), 64'd0);
        chk("t6_rtarget", 64'(redirect_target), 64'd0);
        chk("t6_cnt", 64'(taken_cnt), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);

        // Saturation: 17 taken handshakes on a 4-bit counter
        redirect_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            br_valid = 1'b1; br_op = 1'b1; br_target = 32'h1000 + i;
            a_valid = 1'b1; a_data = 32'h7;
            push_exp(1'b1, 32'h1000 + i);
            step();
            br_valid = 1'b0; a_valid = 1'b0;
            step();
            step();
            chk($sformatf("t7_cnt%0d", i), 64'(taken_cnt),
                64'((i + 1 > 15) ? 15 : i + 1));
        end
        redirect_ready = 1'b0;
        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_branch_eqz_ctrl

// File: doc/branch_eqz_ctrl.md
Name: branch_eqz_ctrl

Overview:
- Sequences branch resolution for BEQZ/BNEZ in the DLX pipeline.
- Accepts a branch request from decode and waits until the A operand is valid (forwarded or read from the register file).
- Evaluates A==0 with the existing 32-bit zero-detect unit, then presents a registered redirect decision to the fetch/PC logic through a valid/ready handshake.
- Handles pipeline flush and keeps a saturating count of taken branches.

Parameters:
- AW, 32, width of the PC / branch target.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- br_valid  input  1  decode presents a branch request.
- br_ready  output  1  controller can accept a request.
- br_op  input  1  0=BEQZ (taken if A==0), 1=BNEZ (taken if A!=0).
- br_target  input  AW  branch target address.
- a_valid  input  1  A operand is valid this cycle.
- a_data  input  32  A operand value.
- flush  input  1  discard any in-flight branch.
- redirect_valid  output  1  decision is available.
- redirect_ready  input  1  PC logic consumes the decision.
- redirect_taken  output  1  1 = branch taken.
- redirect_target  output  AW  captured br_target, meaningful when taken.
- busy  output  1  state != IDLE; used as the decode stall.
- taken_cnt  output  CNT_W  saturating count of consumed taken branches.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset has priority over every other input.
- Reset values: state=IDLE, redirect_valid=0, redirect_taken=0, redirect_target=0, taken_cnt=0, internal op/A registers=0.
- br_ready = (state==IDLE) && !flush. This is combinational.
- busy = (state != IDLE).
- State IDLE:
  - Accept when br_valid && br_ready; latch br_op and br_target.
  - If a_valid is also high that cycle, latch a_data and go to RESOLVE; otherwise go to WAIT_OPND.
- State WAIT_OPND:
  - Hold. On a_valid, latch a_data and go to RESOLVE.
  - No timeout; it waits indefinitely.
- State RESOLVE:
  - zero = (A_latched==0) from the zero-detect sub-module.
  - taken = br_op ? !zero : zero.
  - Register redirect_taken=taken and redirect_target=latched target, set redirect_valid=1, go to REDIRECT.
- State REDIRECT:
  - redirect_valid, redirect_taken and redirect_target stay stable until redirect_ready.
  - On the handshake: go to IDLE, redirect_valid=0 next cycle, and if taken, taken_cnt += 1.
- Latency:
  - Accept with a_valid in cycle 0 -> redirect_valid high in cycle 2.
  - Each cycle of a_valid delay adds 1.
  - Back-to-back throughput is one branch per 3 cycles minimum, because br_ready is only high in IDLE.
- taken_cnt saturates at all-ones and never wraps. It is only updated on a redirect handshake with taken=1.
- Flush:
  - Any state except reset -> IDLE next cycle; redirect_valid=0 next cycle.
  - Latched request is discarded; taken_cnt is not updated.
  - Flush wins over a simultaneous redirect_ready, so that cycle does not count as a handshake.
  - Flush wins over a simultaneous br_valid, so the request is not accepted because br_ready=0.
- a_valid and a_data are ignored in IDLE without an accept, and in RESOLVE and REDIRECT.
- br_op and br_target changes after accept have no effect.
- X-free: the redirect_taken and redirect_target registers only load in RESOLVE.

Decomposition:
- Shared package branch_pkg holds:
  - state encoding: IDLE=2'd0, WAIT_OPND=2'd1, RESOLVE=2'd2, REDIRECT=2'd3;
  - op constants: OP_BEQZ=1'b0, OP_BNEZ=1'b1.
- One sub-module: the existing 32-bit zero-detect unit, instantiated on the latched A register.
- The FSM, counter and output registers stay in branch_eqz_ctrl.

Test Plan:
- BEQZ, A valid immediately: reset, then br_valid=1, br_op=0, a_valid=1, a_data=0, br_target=0x100, redirect_ready=1 -> redirect_valid=1 in cycle 2 with taken=1, target=0x100; taken_cnt=1 after the handshake; br_ready high again in cycle 3.
- BNEZ, late operand: br_op=1 accepted with a_valid=0; a_valid=1 with a_data=0x5 three cycles later -> busy=1 throughout; redirect_valid rises 2 cycles after a_valid with taken=1.
- Not taken, then backpressure:
  - BEQZ with a_data=0xFFFF_FFFF and redirect_ready=0 for 4 cycles -> redirect_valid=1, taken=0, target held stable for 4 cycles.
  - On redirect_ready=1 -> IDLE; taken_cnt unchanged.
- Flush collisions:
  - Flush in WAIT_OPND -> IDLE next cycle; redirect_valid never rises.
  - Flush together with redirect_ready in REDIRECT -> taken_cnt unchanged; br_ready=0 that cycle.
- Reset mid-operation: reset in REDIRECT with redirect_valid=1 -> next cycle redirect_valid=0, taken_cnt=0, state IDLE.
- Saturation: with CNT_W=4, drive 17 taken handshakes -> taken_cnt reaches 4'hF and stays 4'hF.
